fp_sgnj_pipe: RTL and testbench
===============================

Name: fp_sgnj_pipe

Overview:
- Pipelined, elastic sign-injection unit (FSGNJ / FSGNJN / FSGNJX) for half, single and double formats on a 64-bit datapath.
- Single-precision and half-precision results are NaN-boxed into 64 bits.
- Sits in the FPU execute cluster beside the other fixed-latency units; valid/ready on both sides, with a tag carried through for writeback steering.

Parameters:
- STAGES, 2, pipeline depth in register stages (legal 1..4); no-stall latency equals STAGES.
- TAG_W, 5, width of the opaque tag carried alongside each operation.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of all in-flight operations
- in_valid  in  1  operation offered
- in_ready  out  1  unit accepts the operation this cycle
- data1  in  64  magnitude source operand
- data2  in  64  sign source operand
- fmt  in  2  0 = single, 1 = double, 2 = half, 3 = illegal
- rm  in  3  0 = sgnj, 1 = sgnjn, 2 = sgnjx, other = illegal
- tag  in  TAG_W  carried unchanged to out_tag
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- result  out  64  sign-injected, NaN-boxed result
- out_tag  out  TAG_W  tag of the result
- illegal  out  1  fmt = 3 or rm > 2 for this result

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. On reset, every stage valid bit clears. Reset values: out_valid = 0, result = 0, out_tag = 0, illegal = 0, in_ready = 0 during the reset cycle and 1 on the first cycle after it.
- Acceptance: an operation is accepted when in_valid && in_ready. Results are computed combinationally from the inputs and captured into stage 0; later stages only move data.
- Sign selection, with p = sign bit position (15 for half, 31 for single, 63 for double):
  - magnitude bits [p-1:0] are taken from data1;
  - sign bit p = data2[p] (rm 0), ~data2[p] (rm 1), data1[p]^data2[p] (rm 2).
  - Bits above p are all ones for half and single (NaN-box).
- Illegal operation: result = 0 and illegal = 1. It still occupies a slot and still completes in order.
- Stage advance: each stage k holds {valid, result, tag, illegal}. Stage k loads from stage k-1 when stage k is empty or is itself advancing. The last stage advances when out_ready.
- Ready generation:
  - in_ready = !flush && !reset && (!v[0] || v[0] advancing).
  - This is an advance-chain (bubble-collapsing) pipeline: any empty stage is filled even while the output is stalled.
- Latency and throughput: with out_ready held at 1, a result appears exactly STAGES cycles after acceptance, and throughput is 1 operation per cycle.
- Stall: when out_ready = 0, out_valid and all output data stay stable until taken. In-order delivery is guaranteed; there is no reordering and no loss.
- Full condition: with all stages valid and out_ready = 0, in_ready = 0.
- flush:
  - Clears all valid bits at the clock edge.
  - flush concurrent with in_valid: flush wins and the input is not accepted.
  - flush concurrent with out_valid && out_ready: that handshake counts as completed; all other entries are discarded.
  - Payload registers may keep stale data; out_valid = 0 marks it invalid.
- Reset mid-operation: identical to flush, and additionally zeroes the output registers.
- Width: no arithmetic; pure bit selection. fmt and rm are sampled only at acceptance.

Optional Feature:
- Macro: FP_SGNJ_NANBOX_CHECK_EN.
- Defined: for fmt 0 (single) and fmt 2 (half), an operand whose bits above p are not all ones is replaced before sign injection by the canonical NaN of that format: 0x7FC00000 for single, 0x7E00 for half. This applies independently to data1 and data2. Double operands are unaffected.
- Undefined: operand upper bits are ignored and used as supplied. No extra logic and no timing change.
- Latency is identical in both cases.

Test Plan:
- Single sgnj (STAGES=2, out_ready=1): data1=0xFFFFFFFF3F800000, data2=0xFFFFFFFFBF800000, rm=0, tag=3 -> two cycles later result=0xFFFFFFFFBF800000, out_tag=3, illegal=0.
- Double sgnjx: data1=0xC000000000000000, data2=0x8000000000000000, rm=2 -> result=0x4000000000000000.
- Half sgnjn: data1=data2=0xFFFFFFFFFFFF3C00, rm=1 -> result=0xFFFFFFFFFFFFBC00.
- Illegal: fmt=3 with rm=0, then fmt=0 with rm=5 -> two results with result=0 and illegal=1, delivered in order.
- Back-pressure:
  - Stimulus: issue tags 1..6 back-to-back, out_ready=0 for cycles 2..6.
  - Response: in_ready falls once STAGES entries are held; no duplicates; tags emerge 1..6 in order once out_ready=1.
  - Repeat with flush asserted mid-stall: out_valid=0 the next cycle, and the next accepted op emerges after STAGES cycles.
- NaN-box check: fmt=0, data1=0x000000003F800000, data2=0xFFFFFFFF00000000, rm=0:
  - with the macro defined -> result=0xFFFFFFFF7FC00000;
  - with the macro undefined -> result=0xFFFFFFFF3F800000.

Source files
------------

// File: rtl/fp_sgnj_pipe_if.sv
// Handshake bundle for fp_sgnj_pipe: an operation channel in and a result channel out.
// The unit binds to the slave modport; the issuing/consuming side uses master.
interface fp_sgnj_pipe_if #(
    parameter int TAG_W = 5
) ();
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      data1;
    logic [63:0]      data2;
    logic [1:0]       fmt;
    logic [2:0]       rm;
    logic [TAG_W-1:0] tag;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      result;
    logic [TAG_W-1:0] out_tag;
    logic             illegal;

    modport master (
        output in_valid, data1, data2, fmt, rm, tag, out_ready,
        input  in_ready, out_valid, result, out_tag, illegal
    );

    modport slave (
        input  in_valid, data1, data2, fmt, rm, tag, out_ready,
        output in_ready, out_valid, result, out_tag, illegal
    );
endinterface

// File: rtl/fp_sgnj_pipe.sv
// Elastic FSGNJ/FSGNJN/FSGNJX unit (half/single/double, NaN-boxed) with a STAGES-deep advance chain.
// Optional macro FP_SGNJ_NANBOX_CHECK_EN canonicalises improperly boxed half/single operands.
module fp_sgnj_pipe #(
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           flush,
    fp_sgnj_pipe_if.slave  bus
);

    function automatic logic f_sign(input logic [2:0] rm, input logic s1, input logic s2);
        case (rm)
            3'd0:    return s2;
            3'd1:    return ~s2;
            default: return s1 ^ s2;
        endcase
    endfunction

    logic [63:0] w_op1;
    logic [63:0] w_op2;
    logic [63:0] w_res;
    logic        w_ill;
    logic        w_in_ready;

    always_comb begin
        w_op1 = bus.data1;
        w_op2 = bus.data2;
`ifdef FP_SGNJ_NANBOX_CHECK_EN
        if (bus.fmt == 2'd0) begin
            if (!(&bus.data1[63:32])) w_op1 = 64'h0000_0000_7FC0_0000;
            if (!(&bus.data2[63:32])) w_op2 = 64'h0000_0000_7FC0_0000;
        end else if (bus.fmt == 2'd2) begin
            if (!(&bus.data1[63:16])) w_op1 = 64'h0000_0000_0000_7E00;
            if (!(&bus.data2[63:16])) w_op2 = 64'h0000_0000_0000_7E00;
        end
`endif
        w_ill = (bus.fmt == 2'd3) || (bus.rm > 3'd2);
        w_res = '0;
        case (bus.fmt)
            2'd0:    w_res = {32'hFFFF_FFFF, f_sign(bus.rm, w_op1[31], w_op2[31]), w_op1[30:0]};
            2'd1:    w_res = {f_sign(bus.rm, w_op1[63], w_op2[63]), w_op1[62:0]};
            2'd2:    w_res = {48'hFFFF_FFFF_FFFF, f_sign(bus.rm, w_op1[15], w_op2[15]), w_op1[14:0]};
            default: w_res = '0;
        endcase
        if (w_ill) w_res = '0;
    end

    logic [STAGES-1:0]             r_valid;
    logic [STAGES-1:0][63:0]       r_result;
    logic [STAGES-1:0][TAG_W-1:0]  r_tag;
    logic [STAGES-1:0]             r_illegal;

    logic [STAGES-1:0]             w_src_valid;
    logic [STAGES-1:0][63:0]       w_src_result;
    logic [STAGES-1:0][TAG_W-1:0]  w_src_tag;
    logic [STAGES-1:0]             w_src_illegal;
    logic [STAGES-1:0]             w_load;

    // A stage may load when it is empty or its occupant moves on; this lets bubbles collapse under stall.
    always_comb begin
        w_load = '0;
        w_load[STAGES-1] = !r_valid[STAGES-1] || bus.out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_load[k] = !r_valid[k] || w_load[k+1];
        end
    end

    assign w_in_ready = !flush && !reset && w_load[0];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_src
                assign w_src_valid[gi]   = bus.in_valid && w_in_ready;
                assign w_src_result[gi]  = w_res;
                assign w_src_tag[gi]     = bus.tag;
                assign w_src_illegal[gi] = w_ill;
            end else begin : g_src
                assign w_src_valid[gi]   = r_valid[gi-1];
                assign w_src_result[gi]  = r_result[gi-1];
                assign w_src_tag[gi]     = r_tag[gi-1];
                assign w_src_illegal[gi] = r_illegal[gi-1];
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_valid[gi]   <= 1'b0;
                    r_result[gi]  <= '0;
                    r_tag[gi]     <= '0;
                    r_illegal[gi] <= 1'b0;
                end else if (flush) begin
                    r_valid[gi]   <= 1'b0;
                end else if (w_load[gi]) begin
                    r_valid[gi] <= w_src_valid[gi];
                    // Payload only moves with a real entry so a drained output keeps its last value.
                    if (w_src_valid[gi]) begin
                        r_result[gi]  <= w_src_result[gi];
                        r_tag[gi]     <= w_src_tag[gi];
                        r_illegal[gi] <= w_src_illegal[gi];
                    end
                end
            end
        end
    endgenerate

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_valid[STAGES-1];
    assign bus.result    = r_result[STAGES-1];
    assign bus.out_tag   = r_tag[STAGES-1];
    assign bus.illegal   = r_illegal[STAGES-1];

endmodule

// File: tb/tb_fp_sgnj_pipe.sv
// Scoreboard bench for fp_sgnj_pipe: directed vectors, back-pressure, flush, reset and random traffic.
// Honours FP_SGNJ_NANBOX_CHECK_EN in its reference model when the macro is defined.
module tb_fp_sgnj_pipe;
    localparam int STAGES = 2;
    localparam int TAG_W  = 5;

    logic clock = 1'b0;
    logic reset;
    logic flush;

    fp_sgnj_pipe_if #(.TAG_W(TAG_W)) bus ();

    fp_sgnj_pipe #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0]      res;
        logic [TAG_W-1:0] tag;
        logic             ill;
        int               acc;
        bit               lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   cyc = 0;
    int   n_acc = 0;
    bit   rnd_done;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Reference: sign position from the format width, magnitude by mask, box by upper ones.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic [1:0] f, input logic [2:0] r,
                                   input logic [TAG_W-1:0] t);
        exp_t        e;
        int          w;
        int          p;
        logic [63:0] hi;
        logic        s;
        e.tag = t;
        e.acc = 0;
        e.lat = 1'b0;
        if (f == 2'd3 || r > 3'd2) begin
            e.res = '0;
            e.ill = 1'b1;
            return e;
        end
        e.ill = 1'b0;
        w  = (f == 2'd1) ? 64 : (f == 2'd0) ? 32 : 16;
        p  = w - 1;
        hi = (w == 64) ? 64'd0 : (~64'd0 << w);
`ifdef FP_SGNJ_NANBOX_CHECK_EN
        if ((a & hi) != hi) a = (f == 2'd0) ? 64'h7FC0_0000 : 64'h7E00;
        if ((b & hi) != hi) b = (f == 2'd0) ? 64'h7FC0_0000 : 64'h7E00;
`endif
        s = (r == 3'd0) ? b[p] : (r == 3'd1) ? ~b[p] : (a[p] ^ b[p]);
        e.res = hi | (a & ((64'd1 << p) - 64'd1)) | (64'(s) << p);
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Offers one operation, waits (bounded) for acceptance and pushes its expectation.
    task automatic send_raw(input logic [63:0] a, input logic [63:0] b, input logic [1:0] f,
                            input logic [2:0] r, input logic [TAG_W-1:0] t, input bit lat,
                            input logic [63:0] e_res, input logic e_ill);
        exp_t e;
        int   n;
        bit   ok;
        bus.in_valid = 1'b1;
        bus.data1 = a;
        bus.data2 = b;
        bus.fmt   = f;
        bus.rm    = r;
        bus.tag   = t;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clock);
            if (bus.in_ready) ok = 1'b1;
            n++;
        end
        if (ok) begin
            e.res = e_res;
            e.tag = t;
            e.ill = e_ill;
            e.acc = cyc;
            e.lat = lat;
            sb.push_back(e);
            n_acc++;
        end else begin
            n_vec++;
            n_miss++;
            $display("FAIL accept_timeout tag=%0d: in_ready stayed 0, required 1", t);
        end
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [63:0] a, input logic [63:0] b, input logic [1:0] f,
                              input logic [2:0] r, input logic [TAG_W-1:0] t, input bit lat);
        exp_t e;
        e = model(a, b, f, r, t);
        send_raw(a, b, f, r, t, lat, e.res, e.ill);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick(1);
            n++;
        end
        check("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: every output handshake is compared against the head of the scoreboard.
    always @(negedge clock) begin
        exp_t e;
        if (bus.out_valid && bus.out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_output: tag=%0d result=%h, required no output", bus.out_tag, bus.result);
            end else begin
                e = sb.pop_front();
                if (bus.result !== e.res || bus.out_tag !== e.tag || bus.illegal !== e.ill) begin
                    n_miss++;
                    $display("FAIL output: result=%h tag=%0d illegal=%b, required result=%h tag=%0d illegal=%b",
                             bus.result, bus.out_tag, bus.illegal, e.res, e.tag, e.ill);
                end else begin
                    $display("ok   output: result=%h tag=%0d illegal=%b", bus.result, bus.out_tag, bus.illegal);
                end
                if (e.lat) begin
                    n_vec++;
                    if (cyc - e.acc != STAGES) begin
                        n_miss++;
                        $display("FAIL latency tag=%0d: got %0d cycles, required %0d", e.tag, cyc - e.acc, STAGES);
                    end
                end
            end
        end
        if (flush || reset) sb.delete();
    end

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  f;
        logic [2:0]  r;
        int          x;

        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.data1     = '0;
        bus.data2     = '0;
        bus.fmt       = '0;
        bus.rm        = '0;
        bus.tag       = '0;
        bus.out_ready = 1'b0;
        tick(3);
        @(negedge clock);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", bus.result, 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        check("rst_illegal", 64'(bus.illegal), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clock);
        #1;

        // Directed known-answer vectors with the output always ready.
        bus.out_ready = 1'b1;
        send_raw(64'hFFFF_FFFF_3F80_0000, 64'hFFFF_FFFF_BF80_0000, 2'd0, 3'd0, 5'd3, 1'b1,
                 64'hFFFF_FFFF_BF80_0000, 1'b0);
        send_raw(64'hC000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'd1, 3'd2, 5'd4, 1'b1,
                 64'h4000_0000_0000_0000, 1'b0);
        send_raw(64'hFFFF_FFFF_FFFF_3C00, 64'hFFFF_FFFF_FFFF_3C00, 2'd2, 3'd1, 5'd5, 1'b1,
                 64'hFFFF_FFFF_FFFF_BC00, 1'b0);
        send_raw(64'hFFFF_FFFF_3F80_0000, 64'hFFFF_FFFF_BF80_0000, 2'd3, 3'd0, 5'd7, 1'b1,
                 64'd0, 1'b1);
        send_raw(64'hFFFF_FFFF_3F80_0000, 64'hFFFF_FFFF_BF80_0000, 2'd0, 3'd5, 5'd8, 1'b1,
                 64'd0, 1'b1);
`ifdef FP_SGNJ_NANBOX_CHECK_EN
        send_raw(64'h0000_0000_3F80_0000, 64'hFFFF_FFFF_0000_0000, 2'd0, 3'd0, 5'd9, 1'b1,
                 64'hFFFF_FFFF_7FC0_0000, 1'b0);
`else
        send_raw(64'h0000_0000_3F80_0000, 64'hFFFF_FFFF_0000_0000, 2'd0, 3'd0, 5'd9, 1'b1,
                 64'hFFFF_FFFF_3F80_0000, 1'b0);
`endif
        drain();

        // Back-pressure: fill the pipe while stalled, then release.
        bus.out_ready = 1'b0;
        n_acc = 0;
        fork
            begin
                for (int t = 1; t <= 6; t++) begin
                    send_model({$urandom, $urandom}, {$urandom, $urandom}, 2'd1, 3'(t % 3), 5'(t), 1'b0);
                end
            end
            begin
                tick(8);
                @(negedge clock);
                check("full_in_ready", 64'(bus.in_ready), 64'd0);
                check("full_accepted", 64'(n_acc), 64'(STAGES));
                check("stall_out_valid", 64'(bus.out_valid), 64'd1);
                check("stall_out_tag", 64'(bus.out_tag), 64'd1);
                @(posedge clock);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Flush while stalled, with an input offered in the same cycle.
        bus.out_ready = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            send_model({$urandom, $urandom}, {$urandom, $urandom}, 2'd1, 3'd0, 5'(10 + i), 1'b0);
        end
        tick(2);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.fmt = 2'd1;
        bus.rm  = 3'd0;
        bus.tag = 5'd20;
        @(negedge clock);
        check("flush_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clock);
        #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clock);
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
        send_model(64'hFFFF_FFFF_4049_0FDB, 64'hFFFF_FFFF_8000_0000, 2'd0, 3'd0, 5'd21, 1'b1);
        drain();

        // Flush coinciding with an output handshake: only that result survives.
        bus.out_ready = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            send_model({$urandom, $urandom}, {$urandom, $urandom}, 2'd1, 3'd2, 5'(22 + i), 1'b0);
        end
        bus.out_ready = 1'b1;
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        @(negedge clock);
        check("flush_hs_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clock);
        #1;
        drain();

        // Reset in the middle of a stalled operation.
        bus.out_ready = 1'b0;
        send_model(64'h1234_5678_9ABC_DEF0, 64'h8000_0000_0000_0000, 2'd1, 3'd1, 5'd30, 1'b0);
        tick(STAGES + 1);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_result", bus.result, 64'd0);
        check("midrst_out_tag", 64'(bus.out_tag), 64'd0);
        check("midrst_in_ready_after", 64'(bus.in_ready), 64'd1);
        @(posedge clock);
        #1;

        // Random traffic with random gaps and random back-pressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    tick($urandom_range(0, 2));
                    a = {$urandom, $urandom};
                    b = {$urandom, $urandom};
                    x = $urandom_range(0, 3);
                    if (x == 1) a[63:32] = '1;
                    if (x == 2) a[63:16] = '1;
                    x = $urandom_range(0, 3);
                    if (x == 1) b[63:32] = '1;
                    if (x == 2) b[63:16] = '1;
                    x = $urandom_range(0, 9);
                    f = (x == 9) ? 2'd3 : 2'(x % 3);
                    r = ($urandom_range(0, 9) == 9) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                    send_model(a, b, f, r, 5'($urandom), 1'b0);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    tick(1);
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
